dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder on the core's load/store port: accepts one read or write request,
//  models WAIT_STATES wait cycles, then returns a one-cycle response.
//  Little-endian byte-addressed storage; byte/half/word access selected by fun3.
//  Instantiated beside the datapath; the core issues requests from Mem_read/Mem_write.
// PARAMETERS
//  data_memory_size  1024  storage size in bytes (power of 2, >=4)
//  WAIT_STATES       1     extra cycles between accept and response (0..15)
// PORTS
//  clk        in   1   single clock; all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  Mem_read   in   1   load request (qualifies addr/fun3)
//  Mem_write  in   1   store request (qualifies addr/wdata/fun3)
//  fun3       in   3   access size/sign: 0 b, 1 h, 2 w, 4 bu, 5 hu
//  addr       in   32  byte address
//  wdata      in   32  store data, LSB-aligned
//  req_ready  out  1   responder can accept a request this cycle
//  rsp_valid  out  1   one-cycle response strobe
//  rdata      out  32  load data, extended per fun3; 0 for stores and errors
//  rsp_err    out  1   valid with rsp_valid: misaligned, illegal fun3, both strobes, or range
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, rsp_valid=0, rdata=0, rsp_err=0, wait counter 0.
//   Memory contents are not reset.
//  Accept: in IDLE, Mem_read|Mem_write high -> capture addr, wdata, fun3, and op;
//   req_ready drops next cycle. Inputs are ignored outside IDLE.
//  FSM: IDLE -> WAIT (WAIT_STATES>0) or RESP (WAIT_STATES==0).
//   WAIT counts WAIT_STATES cycles -> RESP. RESP -> IDLE.
//   rsp_valid=1 only in RESP; req_ready=1 only in IDLE.
//  Latency: rsp_valid asserts WAIT_STATES+1 cycles after the accept edge.
//   Back-to-back throughput is one request per WAIT_STATES+2 cycles.
//  Store commits on the edge entering RESP, writing only the addressed byte lanes.
//   Load data sampled on the same edge, so a load after a store sees the new data.
//  Load extension: fun3 0/1 sign-extend from bit 7/15; 4/5 zero-extend; 2 full word.
//  Errors, checked at accept: each sets rsp_err=1, rdata=0, memory untouched.
//   Mem_read and Mem_write both high.
//   Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
//   Illegal fun3: load 3/6/7; store anything other than 0/1/2.
//  rdata and rsp_err hold their value after RESP until the next response.
//  Reset mid-transaction aborts it: pending store is not written, no response emitted.
// CONFIGURATION
//  DMEM_BOUNDS_CHECK_EN defined:
//   addr >= data_memory_size -> rsp_err=1, rdata=0, no write.
//  Undefined: address wraps as addr mod data_memory_size, never an error.
// TESTING
//  1 reset mid-WAIT of sw 0x10 -> after release req_ready=1, rsp_valid=0; lw 0x10 returns old data
//  2 sw 0x8=0xDEADBEEF, lw 0x8 -> rdata=0xDEADBEEF, rsp_valid at accept+2 (WAIT_STATES=1)
//  3 sb 0x9=0x80, then lb 0x9 -> 0xFFFFFF80; lbu 0x9 -> 0x00000080; lw 0x8 -> 0xDEAD80EF
//  4 sh 0xA=0x8001, then lh 0xA -> 0xFFFF8001; lhu 0xA -> 0x00008001
//  5 lw 0x6, sh 0x3, read+write together -> each rsp_err=1, rdata=0; then lw 0x4 unchanged
//  6 lw 0x404 with size 1024 -> with _EN rsp_err=1; without, returns word at 0x004

Source files
------------

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Wait-state data-memory responder for the core load/store port.
//               Byte-addressed little-endian storage with b/h/w access.
//               Optional macro DMEM_BOUNDS_CHECK_EN flags out-of-range addresses
//               instead of wrapping them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int data_memory_size = 1024,
  parameter int WAIT_STATES      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_read,
  input  logic        Mem_write,
  input  logic [2:0]  fun3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(data_memory_size);
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  fun3_q, fun3_d;
  logic        store_q, store_d;
  logic        both_q, both_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [7:0]  mem [data_memory_size];

  logic          w_idle;
  logic          w_accept;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [2:0]    w_fun3;
  logic          w_store;
  logic          w_both;
  logic          w_misaligned;
  logic          w_bad_fun3;
  logic          w_range_err;
  logic          w_err;
  logic          w_enter_resp;
  logic          w_wr_en;
  logic [3:0]    w_lane_en;
  logic [AW-1:0] w_base;
  logic [AW-1:0] w_lane_addr [4];
  logic [7:0]    w_rd_byte [4];
  logic [31:0]   w_load_data;

  // In IDLE the transaction is still on the input pins; afterwards it lives in the capture regs.
  assign w_idle   = (state_q == S_IDLE);
  assign w_accept = w_idle && (Mem_read || Mem_write);
  assign w_addr   = w_idle ? addr : addr_q;
  assign w_wdata  = w_idle ? wdata : wdata_q;
  assign w_fun3   = w_idle ? fun3 : fun3_q;
  assign w_store  = w_idle ? Mem_write : store_q;
  assign w_both   = w_idle ? (Mem_read && Mem_write) : both_q;
  assign w_base   = w_addr[AW-1:0];

  always_comb begin
    w_misaligned = 1'b0;
    case (w_fun3[1:0])
      2'b01:   w_misaligned = w_addr[0];
      2'b10:   w_misaligned = (w_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    w_bad_fun3 = 1'b0;
    if (w_store) begin
      w_bad_fun3 = !(w_fun3 inside {3'd0, 3'd1, 3'd2});
    end else begin
      w_bad_fun3 = !(w_fun3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  assign w_range_err = (w_addr >= 32'(data_memory_size));
`else
  // Without the bounds check the upper address bits are simply discarded (wrap).
  logic unused_hi_addr;
  assign unused_hi_addr = ^w_addr[31:AW];
  assign w_range_err    = 1'b0;
`endif

  assign w_err = w_both || w_misaligned || w_bad_fun3 || w_range_err;

  assign w_enter_resp = (w_accept && (WAIT_STATES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == WAIT_LAST));
  assign w_wr_en      = w_enter_resp && w_store && !w_err;

  always_comb begin
    w_lane_en = 4'b1111;
    case (w_fun3[1:0])
      2'b00:   w_lane_en = 4'b0001;
      2'b01:   w_lane_en = 4'b0011;
      default: w_lane_en = 4'b1111;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_lane_addr[i] = w_base + AW'(i);
    assign w_rd_byte[i]   = mem[w_lane_addr[i]];
  end

  always_comb begin
    w_load_data = 32'd0;
    case (w_fun3)
      3'd0:    w_load_data = {{24{w_rd_byte[0][7]}}, w_rd_byte[0]};
      3'd1:    w_load_data = {{16{w_rd_byte[1][7]}}, w_rd_byte[1], w_rd_byte[0]};
      3'd2:    w_load_data = {w_rd_byte[3], w_rd_byte[2], w_rd_byte[1], w_rd_byte[0]};
      3'd4:    w_load_data = {24'd0, w_rd_byte[0]};
      3'd5:    w_load_data = {16'd0, w_rd_byte[1], w_rd_byte[0]};
      default: w_load_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fun3_d      = fun3_q;
    store_d     = store_q;
    both_d      = both_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          addr_d  = addr;
          wdata_d = wdata;
          fun3_d  = fun3;
          store_d = Mem_write;
          both_d  = Mem_read && Mem_write;
          cnt_d   = 4'd0;
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response fields are sampled on the edge entering RESP and held until the next one.
    if (w_enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = w_err;
      rdata_d     = (w_store || w_err) ? 32'd0 : w_load_data;
    end
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      fun3_q      <= 3'd0;
      store_q     <= 1'b0;
      both_q      <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fun3_q      <= fun3_d;
      store_q     <= store_d;
      both_q      <= both_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en && w_lane_en[i]) begin
        mem[w_lane_addr[i]] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire
